// File: rtl/pll_phase_shift_sequencer.sv
// Purpose: steps the PLL dynamic phase-shift port N times on counter A, then N times on counter B.
// Latency: o_done two cycles after start when there is no work; otherwise set by the phasedone handshake.
// Backpressure: a start request is taken only in IDLE; one that arrives while a sequence runs is dropped.
//
// Ports:
//   i_clk, i_rst_n          scanclk and synchronous active-low reset
//   i_start                 1-cycle request; latches i_steps, i_sel_a, i_sel_b, i_en_mask, i_up
//   i_phasedone             PLL phasedone, asynchronous to this logic; goes through 2 flops
//   o_phasestep             PLL phasestep, high for STEP_HOLD cycles per step
//   o_phaseupdown           PLL phaseupdown, holds the latched i_up
//   o_phasecounterselect    PLL counter select; holds its value between steps and after DONE
//   o_busy, o_done, o_err   status: sequence running, end pulse, sticky timeout flag
//   o_steps_done            steps completed in the current or last sequence
module pll_phase_shift_sequencer #(
   parameter int STEP_HOLD = 2,
   parameter int TIMEOUT   = 255,
   parameter int SEL_W     = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [7:0]       i_steps,
   input  logic [SEL_W-1:0] i_sel_a,
   input  logic [SEL_W-1:0] i_sel_b,
   input  logic [1:0]       i_en_mask,
   input  logic             i_up,
   input  logic             i_phasedone,
   output logic             o_phasestep,
   output logic             o_phaseupdown,
   output logic [SEL_W-1:0] o_phasecounterselect,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [8:0]       o_steps_done
);

   typedef enum logic [2:0] {
      IDLE, PICK, SETUP, STEP, WAIT_LO, WAIT_HI, DONE
   } state_t;

   state_t           state;
   logic             pd_meta, pd_sync;
   logic [7:0]       steps_l;
   logic [SEL_W-1:0] sel_a_l, sel_b_l;
   logic [1:0]       mask_l;
   logic             up_l;
   logic [7:0]       remaining;
   logic             ch;         // 0 = counter A, 1 = counter B
   logic [1:0]       fin;        // channels already run to completion
   logic [7:0]       hold_cnt;
   logic [7:0]       to_cnt;

   // Every channel receives the same step count, so a channel is eligible
   // when it is enabled, not yet finished and the count is nonzero.
   logic elig_a, elig_b;
   assign elig_a = mask_l[0] & ~fin[0] & (steps_l != 8'd0);
   assign elig_b = mask_l[1] & ~fin[1] & (steps_l != 8'd0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state                <= IDLE;
         pd_meta              <= 1'b1;
         pd_sync              <= 1'b1;
         steps_l              <= '0;
         sel_a_l              <= '0;
         sel_b_l              <= '0;
         mask_l               <= '0;
         up_l                 <= 1'b0;
         remaining            <= '0;
         ch                   <= 1'b0;
         fin                  <= '0;
         hold_cnt             <= '0;
         to_cnt               <= '0;
         o_phasestep          <= 1'b0;
         o_phaseupdown        <= 1'b0;
         o_phasecounterselect <= SEL_W'(3'b110);
         o_busy               <= 1'b0;
         o_done               <= 1'b0;
         o_err                <= 1'b0;
         o_steps_done         <= '0;
      end else begin
         pd_meta <= i_phasedone;
         pd_sync <= pd_meta;
         case (state)
            IDLE: begin
               if (i_start) begin
                  steps_l      <= i_steps;
                  sel_a_l      <= i_sel_a;
                  sel_b_l      <= i_sel_b;
                  mask_l       <= i_en_mask;
                  up_l         <= i_up;
                  fin          <= '0;
                  o_err        <= 1'b0;
                  o_steps_done <= '0;
                  o_busy       <= 1'b1;
                  state        <= PICK;
               end
            end
            PICK: begin
               if (elig_a || elig_b) begin
                  ch                   <= ~elig_a;
                  o_phasecounterselect <= elig_a ? sel_a_l : sel_b_l;
                  o_phaseupdown        <= up_l;
                  remaining            <= steps_l;
                  state                <= SETUP;
               end else begin
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= DONE;
               end
            end
            SETUP: begin
               o_phasestep <= 1'b1;
               hold_cnt    <= '0;
               state       <= STEP;
            end
            STEP: begin
               if (hold_cnt == 8'(STEP_HOLD - 1)) begin
                  o_phasestep <= 1'b0;
                  to_cnt      <= '0;
                  state       <= WAIT_LO;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            WAIT_LO, WAIT_HI: begin
               // WAIT_LO waits for the PLL to start the shift, WAIT_HI for it to finish.
               if ((state == WAIT_LO) && !pd_sync) begin
                  to_cnt <= '0;
                  state  <= WAIT_HI;
               end else if ((state == WAIT_HI) && pd_sync) begin
                  remaining    <= remaining - 8'd1;
                  o_steps_done <= o_steps_done + 9'd1;
                  if (remaining != 8'd1) begin
                     state <= SETUP;
                  end else begin
                     fin[ch] <= 1'b1;
                     state   <= PICK;
                  end
               end else if (to_cnt == 8'(TIMEOUT - 1)) begin
                  // Waited TIMEOUT cycles with no edge: abandon the rest of the sequence.
                  o_err       <= 1'b1;
                  o_phasestep <= 1'b0;
                  o_busy      <= 1'b0;
                  o_done      <= 1'b1;
                  state       <= DONE;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            DONE: begin
               o_done <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
